// File: rtl/fifo_read_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_counter_pkg
// Description : Shared widths and helpers for the FIFO read-side counter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_read_counter_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int FIFO_DEPTH = 2 ** ADDR_WIDTH;

  typedef logic [PTR_WIDTH-1:0]  ptr_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // 5-bit 2:1 mux cell: returns b when sel is high, a otherwise.
  function automatic ptr_t mux2_5b(input ptr_t a, input ptr_t b, input logic sel);
    ptr_t y;
    y = sel ? b : a;
    return y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_read_counter_incr.sv
`default_nettype none
// ============================================================================
// Module      : ptr_incrementer_5b
// Description : Structural +1 on the read pointer built from a half-adder
//               chain; the carry out of the top bit is dropped so the result
//               wraps modulo 2**PTR_WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module ptr_incrementer_5b
  import fifo_read_counter_pkg::*;
(
  input  logic [PTR_WIDTH-1:0] a,
  output logic [PTR_WIDTH-1:0] sum
);

  // carry[0] is the constant +1 injected at the LSB
  logic [PTR_WIDTH-1:0] carry;

  assign carry[0] = 1'b1;

  // Half-adder per bit; the last stage has no carry output
  for (genvar i = 0; i < PTR_WIDTH; i++) begin : g_half_add
    assign sum[i] = a[i] ^ carry[i];
    if (i < PTR_WIDTH - 1) begin : g_carry
      assign carry[i+1] = a[i] & carry[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_read_counter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_counter
// Description : Read-side pointer of the 16-entry FIFO. Advances the read
//               pointer on accepted reads, derives Empty/Count against the
//               write pointer, and produces ReadValid and Underflow strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_read_counter
  import fifo_read_counter_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  ReadEnable,
  input  logic                  Flush,
  input  logic [PTR_WIDTH-1:0]  WritePointer,
  output logic [PTR_WIDTH-1:0]  ReadPointer,
  output logic [ADDR_WIDTH-1:0] ReadAddress,
  output logic                  Empty,
  output logic [PTR_WIDTH-1:0]  Count,
  output logic                  ReadValid,
  output logic                  Underflow
);

  logic [PTR_WIDTH-1:0] read_ptr;
  logic [PTR_WIDTH-1:0] ptr_plus_one;
  logic [PTR_WIDTH-1:0] ptr_after_read;
  logic [PTR_WIDTH-1:0] ptr_next;
  logic                 accepted;
  logic                 rejected;
  logic                 read_valid;
  logic                 underflow;

  ptr_incrementer_5b u_incr (
    .a   (read_ptr),
    .sum (ptr_plus_one)
  );

  // Empty is judged against the current write pointer, so a write landing in
  // the same cycle only makes the read succeed on the following cycle.
  always_comb begin
    Empty          = (read_ptr == WritePointer);
    Count          = WritePointer - read_ptr;
    accepted       = ReadEnable & ~Empty;
    rejected       = ReadEnable & Empty;
    ptr_after_read = mux2_5b(read_ptr, ptr_plus_one, accepted);
    ptr_next       = mux2_5b(ptr_after_read, WritePointer, Flush);
  end

  // Pointer and strobe registers: Reset > Flush > accepted read > hold
  always_ff @(posedge Clock) begin
    if (Reset) begin
      read_ptr   <= '0;
      read_valid <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      read_ptr   <= ptr_next;
      read_valid <= accepted & ~Flush;
      underflow  <= rejected & ~Flush;
    end
  end

  assign ReadPointer = read_ptr;
  assign ReadAddress = read_ptr[ADDR_WIDTH-1:0];
  assign ReadValid   = read_valid;
  assign Underflow   = underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_counter
// Description : Directed table-driven bench for fifo_read_counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_read_counter;
  import fifo_read_counter_pkg::*;

  logic                  Clock = 1'b0;
  logic                  Reset;
  logic                  ReadEnable;
  logic                  Flush;
  logic [PTR_WIDTH-1:0]  WritePointer;
  logic [PTR_WIDTH-1:0]  ReadPointer;
  logic [ADDR_WIDTH-1:0] ReadAddress;
  logic                  Empty;
  logic [PTR_WIDTH-1:0]  Count;
  logic                  ReadValid;
  logic                  Underflow;

  int checks = 0;
  int errors = 0;

  fifo_read_counter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .ReadEnable   (ReadEnable),
    .Flush        (Flush),
    .WritePointer (WritePointer),
    .ReadPointer  (ReadPointer),
    .ReadAddress  (ReadAddress),
    .Empty        (Empty),
    .Count        (Count),
    .ReadValid    (ReadValid),
    .Underflow    (Underflow)
  );

  // 10 ns clock
  always #5 Clock = ~Clock;

  // Inputs applied for one edge; expectations observed just after that edge
  typedef struct {
    logic       rst;
    logic       fl;
    logic       re;
    logic [4:0] wp;
    logic [4:0] rp;
    logic       empty;
    logic [4:0] cnt;
    logic       rv;
    logic       uf;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic fl, input logic re, input logic [4:0] wp);
    @(negedge Clock);
    Reset = rst; Flush = fl; ReadEnable = re; WritePointer = wp;
    @(posedge Clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [4:0] rp, input logic empty,
                           input logic [4:0] cnt, input logic rv, input logic uf);
    chk({tag, ".ReadPointer"}, int'(ReadPointer), int'(rp));
    chk({tag, ".ReadAddress"}, int'(ReadAddress), int'(rp[3:0]));
    chk({tag, ".Empty"},       int'(Empty),       int'(empty));
    chk({tag, ".Count"},       int'(Count),       int'(cnt));
    chk({tag, ".ReadValid"},   int'(ReadValid),   int'(rv));
    chk({tag, ".Underflow"},   int'(Underflow),   int'(uf));
  endtask

  initial begin
    Reset = 1'b1; Flush = 1'b0; ReadEnable = 1'b0; WritePointer = '0;

    //          rst   fl    re    wp     rp     empty cnt    rv    uf
    // reset state
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 1'b0};
    // three entries drained, fourth request underflows
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd1,  1'b0, 5'd2,  1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd2,  1'b0, 5'd1,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  1'b1, 5'd0,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd3,  5'd3,  1'b1, 5'd0,  1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd3,  5'd3,  1'b1, 5'd0,  1'b0, 1'b0};
    // preload 30 via Flush, then wrap through 31 -> 0
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd30, 5'd30, 1'b1, 5'd0,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd2,  5'd31, 1'b0, 5'd3,  1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 5'd2,  5'd0,  1'b0, 5'd2,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 5'd2,  5'd1,  1'b0, 5'd1,  1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd2,  5'd2,  1'b1, 5'd0,  1'b1, 1'b0};
    // full: 16 entries, read accepted
    vecs[11] = '{1'b1, 1'b0, 1'b0, 5'd16, 5'd0,  1'b0, 5'd16, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 5'd16, 5'd1,  1'b0, 5'd15, 1'b1, 1'b0};
    // flush wins over a concurrent read
    vecs[13] = '{1'b0, 1'b0, 1'b1, 5'd9,  5'd2,  1'b0, 5'd7,  1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 5'd9,  5'd9,  1'b1, 5'd0,  1'b0, 1'b0};
    // flush with a read on empty suppresses the underflow
    vecs[15] = '{1'b0, 1'b1, 1'b1, 5'd9,  5'd9,  1'b1, 5'd0,  1'b0, 1'b0};

    // ReadAddress presents the entry in the request cycle, before the edge
    step(1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge Clock);
    Reset = 1'b0; ReadEnable = 1'b1; WritePointer = 5'd3;
    #1;
    chk("req_cycle.ReadAddress", int'(ReadAddress), 0);
    chk("req_cycle.Count", int'(Count), 3);
    chk("req_cycle.ReadValid", int'(ReadValid), 0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].fl, vecs[i].re, vecs[i].wp);
      check_all($sformatf("vec%0d", i), vecs[i].rp, vecs[i].empty,
                vecs[i].cnt, vecs[i].rv, vecs[i].uf);
    end

    // Reset mid-burst squashes the pending ReadValid
    step(1'b1, 1'b0, 1'b0, 5'd10);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 5'd10);
    check_all("burst", 5'd5, 1'b0, 5'd5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 5'd10);
    check_all("mid_reset", 5'd0, 1'b0, 5'd10, 1'b0, 1'b0);

    // A write arriving alongside the read: rejected now, accepted next cycle
    step(1'b1, 1'b0, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b1, 5'd0);
    check_all("same_cycle_write", 5'd0, 1'b1, 5'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 5'd1);
    check_all("next_cycle_read", 5'd1, 1'b1, 5'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_read_counter.md
Name: fifo_read_counter

Overview:
Read-side pointer/counter for the 16-entry structural FIFO. It is the consumer-end counterpart of the write-pointer path. It advances a 5-bit read pointer (4 address bits plus a wrap bit) on accepted reads and compares it against the write pointer to produce Empty and Count. It also produces a registered read-valid strobe and an underflow pulse. It sits between the FIFO storage array's read address and the downstream consumer.

Parameters:
PTR_WIDTH, 5, pointer width: ADDR_WIDTH plus 1 wrap bit.
ADDR_WIDTH, 4, storage address width; depth = 2**ADDR_WIDTH = 16.

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
ReadEnable  input  1  consumer read request.
Flush  input  1  synchronous clear; sets the read pointer equal to WritePointer.
WritePointer  input  PTR_WIDTH  write pointer from the write side, same clock domain.
ReadPointer  output  PTR_WIDTH  registered read pointer.
ReadAddress  output  ADDR_WIDTH  ReadPointer[ADDR_WIDTH-1:0], to the storage array.
Empty  output  1  combinational: ReadPointer == WritePointer.
Count  output  PTR_WIDTH  combinational: (WritePointer - ReadPointer) mod 2**PTR_WIDTH, range 0..16.
ReadValid  output  1  registered; high the cycle after an accepted read.
Underflow  output  1  registered one-cycle pulse, the cycle after a rejected read.

Behaviour:
- One clock, Clock. Reset is synchronous and active-high.
- Reset values: ReadPointer = 0, ReadValid = 0, Underflow = 0. Empty and Count then follow from WritePointer (Empty = 1 when WritePointer = 0).
- Accept: accepted = ReadEnable & ~Empty, evaluated before the clock edge.
- On an accepted read, ReadPointer <= ReadPointer + 1, modulo 32. 31 -> 0 wraps naturally and toggles the wrap bit.
- Otherwise ReadPointer holds.
- The next-pointer choice is a 2:1 selection between hold and increment, controlled by accepted.
- Latency:
  - ReadAddress presents the entry to read in the request cycle.
  - ReadValid asserts exactly 1 cycle later, marking data valid from the registered array output.
- Rejected read: ReadEnable & Empty leaves the pointer unchanged, sets Underflow = 1 for one cycle, and keeps ReadValid = 0.
- Full (Count = 16, pointers differ only in the MSB): reads are accepted normally. Full detection is owned by the write side.
- Flush (Reset low):
  - ReadPointer <= WritePointer.
  - ReadValid <= 0 and Underflow <= 0, regardless of ReadEnable.
  - Flush has priority over the read.
- Priority: Reset > Flush > accepted read > hold.
- Reset mid-burst: the pointer returns to 0 on the next edge, and any pending ReadValid is squashed.
- A simultaneous write that makes the FIFO non-empty in the same cycle does not enable the read. Empty uses the current WritePointer value, so the read succeeds the next cycle.
- No state machine beyond the pointer and the two strobe flops. All registers update on the rising edge only.

Decomposition:
- Shared package/constants file: PTR_WIDTH, ADDR_WIDTH, FIFO_DEPTH = 16.
- One natural sub-module: ptr_incrementer_5b, a structural 5-bit +1 (half-adder chain).
- The next-pointer select reuses the team's existing 5-bit 2:1 mux cell.
- The Flush path is a second 5-bit 2:1 selection ahead of the pointer register.

Test Plan:
- Reset with WritePointer = 0 -> ReadPointer = 0, Empty = 1, Count = 0, ReadValid = 0, Underflow = 0.
- WritePointer = 3, ReadEnable held 4 cycles -> ReadPointer goes 1, 2, 3 then holds. ReadValid is high for 3 cycles, lagging the requests by 1. The 4th request gives Underflow = 1 for one cycle. Empty = 1 at ReadPointer = 3.
- Wrap: preload to ReadPointer = 30 (via Flush with WritePointer = 30), then set WritePointer = 2 and issue 4 reads -> 31, 0, 1, 2. ReadAddress goes 15, 0, 1, 2. Count goes 4, 3, 2, 1, 0.
- Full: ReadPointer = 0, WritePointer = 16 -> Count = 16, Empty = 0. One read -> ReadPointer = 1, Count = 15.
- Flush during a read: ReadPointer = 2, WritePointer = 9, ReadEnable = 1 and Flush = 1 -> ReadPointer = 9, ReadValid = 0, Empty = 1.
- Reset mid-burst: reads in progress with ReadPointer = 5 and Reset = 1 -> the next cycle gives ReadPointer = 0 and ReadValid = 0, even though the previous cycle was an accepted read.
